// File: rtl/reg_bank.sv
// reg_bank: DEPTH x DATA_WIDTH register file with one write port, two
// combinational read ports (A, B), optional write-to-read bypass, R0 gating
// on port A through BAout, and a per-register busy scoreboard for detecting
// RAW hazards on multi-cycle instructions.
module reg_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter bit                    BYPASS     = 1'b1,
    parameter bit                    R0_GATE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    input  logic                  BAout,
    input  logic                  reserve,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    output logic [DATA_WIDTH-1:0] ra_data,
    output logic [DATA_WIDTH-1:0] rb_data,
    output logic [DEPTH-1:0]      busy,
    output logic                  hazard,
    output logic                  reserve_err
);

    // Storage and scoreboard state
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic                  reserve_err_q;
    logic                  reserve_err_d;

    // One-hot decodes of the write and reserve targets
    logic [DEPTH-1:0]      wsel;
    logic [DEPTH-1:0]      rsel;

    // Write/bypass hit on a read port; clr suppresses the write entirely
    logic                  a_bypass_hit;
    logic                  b_bypass_hit;
    logic                  a_r0_gated;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_decode
            assign wsel[gi] = we      && (waddr        == ADDR_WIDTH'(gi));
            assign rsel[gi] = reserve && (reserve_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Next-state for data registers and busy flags; a reserve to the same
    // register as a write keeps it busy (set wins over clear)
    always_comb begin
        busy_d        = busy_q;
        reserve_err_d = reserve & busy_q[reserve_addr];
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wsel[i]) begin
                regs_d[i] = wdata;
                busy_d[i] = 1'b0;
            end
            if (rsel[i]) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // State registers; clr discards any write or reservation in its cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= INIT;
            end
            busy_q        <= '0;
            reserve_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            reserve_err_q <= reserve_err_d;
        end
    end

    // Read ports: R0 gate (port A only) beats bypass, bypass beats storage
    always_comb begin
        a_bypass_hit = BYPASS && we && !clr && (waddr == ra_addr);
        b_bypass_hit = BYPASS && we && !clr && (waddr == rb_addr);
        a_r0_gated   = R0_GATE && BAout && (ra_addr == '0);

        ra_data = regs_q[ra_addr];
        if (a_bypass_hit) begin
            ra_data = wdata;
        end
        if (a_r0_gated) begin
            ra_data = '0;
        end

        rb_data = regs_q[rb_addr];
        if (b_bypass_hit) begin
            rb_data = wdata;
        end
    end

    // Hazard looks only at registered busy flags, so a same-cycle write
    // does not clear it until the following cycle
    always_comb begin
        hazard = busy_q[ra_addr] | busy_q[rb_addr];
    end

    assign busy        = busy_q;
    assign reserve_err = reserve_err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank: directed table vectors, a parameter-sweep instance,
// and randomized traffic checked against a behavioural model.
module tb_reg_bank;

    logic        clk;
    logic        clr, we, ba, res;
    logic [3:0]  waddr, ra, rb, raddr;
    logic [31:0] wdata;
    logic [31:0] ra_data, rb_data;
    logic [15:0] busy;
    logic        hazard, rerr;

    // Small instance: 8-bit, 4 deep, no bypass, INIT=3C
    logic        s_clr, s_we, s_ba, s_res;
    logic [1:0]  s_waddr, s_ra, s_rb, s_raddr;
    logic [7:0]  s_wdata, s_ra_data, s_rb_data;
    logic [3:0]  s_busy;
    logic        s_hazard, s_rerr;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra), .rb_addr(rb), .BAout(ba), .reserve(res),
        .reserve_addr(raddr), .ra_data(ra_data), .rb_data(rb_data),
        .busy(busy), .hazard(hazard), .reserve_err(rerr)
    );

    reg_bank #(
        .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .INIT(8'h3C),
        .BYPASS(1'b0), .R0_GATE(1'b1)
    ) dut2 (
        .clk(clk), .clr(s_clr), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .ra_addr(s_ra), .rb_addr(s_rb), .BAout(s_ba), .reserve(s_res),
        .reserve_addr(s_raddr), .ra_data(s_ra_data), .rb_data(s_rb_data),
        .busy(s_busy), .hazard(s_hazard), .reserve_err(s_rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic [3:0] wa,
                         input logic [31:0] wd, input logic [3:0] a, input logic [3:0] b,
                         input logic bao, input logic r, input logic [3:0] radr);
        clr = c; we = w; waddr = wa; wdata = wd; ra = a; rb = b;
        ba = bao; res = r; raddr = radr;
    endtask

    typedef struct {
        logic        clr, we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  ra, rb;
        logic        ba, res;
        logic [3:0]  raddr;
        logic [31:0] exp_ra, exp_rb;
        logic        exp_haz;
        logic [15:0] exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t tbl [16];

    // Behavioural model for the random phase
    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic        m_err;

    function automatic logic [3:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [31:0] e_ra, e_rb;
        logic        e_haz;

        //        clr we wa  wdata          ra rb ba res radr  exp_ra         exp_rb         hz busy     err
        tbl[0]  = '{1, 1, 3, 32'hDEAD_BEEF, 3, 3, 0, 0, 0, 32'h0,         32'h0,         0, 16'h0000, 0};
        tbl[1]  = '{0, 0, 0, 32'h0,         3, 3, 0, 0, 0, 32'h0,         32'h0,         0, 16'h0000, 0};
        tbl[2]  = '{0, 1, 5, 32'h1234_5678, 5, 0, 0, 0, 0, 32'h1234_5678, 32'h0,         0, 16'h0000, 0};
        tbl[3]  = '{0, 0, 0, 32'h0,         5, 5, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 0, 16'h0000, 0};
        tbl[4]  = '{0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 32'h0,         32'hFFFF_FFFF, 0, 16'h0000, 0};
        tbl[5]  = '{0, 0, 0, 32'h0,         0, 0, 1, 0, 0, 32'h0,         32'hFFFF_FFFF, 0, 16'h0000, 0};
        tbl[6]  = '{0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 16'h0000, 0};
        tbl[7]  = '{0, 0, 0, 32'h0,         7, 0, 0, 1, 7, 32'h0,         32'hFFFF_FFFF, 0, 16'h0080, 0};
        tbl[8]  = '{0, 0, 0, 32'h0,         7, 1, 0, 0, 0, 32'h0,         32'h0,         1, 16'h0080, 0};
        tbl[9]  = '{0, 1, 7, 32'h0000_00A5, 7, 0, 0, 0, 0, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 16'h0000, 0};
        tbl[10] = '{0, 0, 0, 32'h0,         7, 1, 0, 0, 0, 32'h0000_00A5, 32'h0,         0, 16'h0000, 0};
        tbl[11] = '{0, 0, 0, 32'h0,         2, 2, 0, 1, 2, 32'h0,         32'h0,         0, 16'h0004, 0};
        tbl[12] = '{0, 1, 2, 32'h0000_0055, 2, 7, 0, 1, 2, 32'h0000_0055, 32'h0000_00A5, 1, 16'h0004, 1};
        tbl[13] = '{0, 0, 0, 32'h0,         2, 0, 0, 0, 0, 32'h0000_0055, 32'hFFFF_FFFF, 1, 16'h0004, 0};
        tbl[14] = '{1, 1, 5, 32'h0000_0001, 5, 2, 0, 1, 9, 32'h1234_5678, 32'h0000_0055, 1, 16'h0000, 0};
        tbl[15] = '{0, 0, 0, 32'h0,         5, 0, 0, 0, 0, 32'h0,         32'h0,         0, 16'h0000, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        s_clr = 1; s_we = 0; s_waddr = 0; s_wdata = 0; s_ra = 0; s_rb = 0;
        s_ba = 0; s_res = 0; s_raddr = 0;
        @(posedge clk);

        // Directed table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].clr, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].ra,
                  tbl[i].rb, tbl[i].ba, tbl[i].res, tbl[i].raddr);
            #1;
            check($sformatf("tbl%0d ra_data", i), ra_data, tbl[i].exp_ra);
            check($sformatf("tbl%0d rb_data", i), rb_data, tbl[i].exp_rb);
            check($sformatf("tbl%0d hazard", i), {31'b0, hazard}, {31'b0, tbl[i].exp_haz});
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d busy", i), {16'b0, busy}, {16'b0, tbl[i].exp_busy});
            check($sformatf("tbl%0d reserve_err", i), {31'b0, rerr}, {31'b0, tbl[i].exp_err});
        end

        // Parameter sweep instance: INIT after clr, no bypass
        @(negedge clk);
        s_clr = 0;
        for (int a = 0; a < 4; a++) begin
            s_ra = 2'(a); s_rb = 2'(3 - a);
            #1;
            check($sformatf("sweep init ra%0d", a), {24'b0, s_ra_data}, 32'h3C);
            check($sformatf("sweep init rb%0d", 3 - a), {24'b0, s_rb_data}, 32'h3C);
        end
        check("sweep busy after clr", {28'b0, s_busy}, 32'h0);
        check("sweep hazard after clr", {31'b0, s_hazard}, 32'h0);
        s_we = 1; s_waddr = 1; s_wdata = 8'hA7; s_ra = 1; s_rb = 1;
        #1;
        check("sweep no bypass ra", {24'b0, s_ra_data}, 32'h3C);
        check("sweep no bypass rb", {24'b0, s_rb_data}, 32'h3C);
        @(posedge clk);
        #1;
        s_we = 0;
        #1;
        check("sweep after edge ra", {24'b0, s_ra_data}, 32'hA7);
        check("sweep after edge rb", {24'b0, s_rb_data}, 32'hA7);

        // Randomized traffic against the model, starting from a clr cycle
        for (int k = 0; k < 16; k++) m_regs[k] = 32'h0;
        m_busy = '0;
        m_err  = 1'b0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), pick_addr(),
                  $urandom, pick_addr(), pick_addr(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), pick_addr());
            #1;
            // Port reads from the rules: gate, then bypass, then stored value
            if (ba && ra == 0)                     e_ra = 32'h0;
            else if (we && !clr && waddr == ra)    e_ra = wdata;
            else                                   e_ra = m_regs[ra];
            if (we && !clr && waddr == rb)         e_rb = wdata;
            else                                   e_rb = m_regs[rb];
            e_haz = m_busy[ra] || m_busy[rb];
            check($sformatf("rnd%0d ra_data", n), ra_data, e_ra);
            check($sformatf("rnd%0d rb_data", n), rb_data, e_rb);
            check($sformatf("rnd%0d hazard", n), {31'b0, hazard}, {31'b0, e_haz});
            @(posedge clk);
            if (clr) begin
                for (int k = 0; k < 16; k++) m_regs[k] = 32'h0;
                m_busy = '0;
                m_err  = 1'b0;
            end else begin
                m_err = res && m_busy[raddr];
                if (we) begin
                    m_regs[waddr] = wdata;
                    m_busy[waddr] = 1'b0;
                end
                if (res) m_busy[raddr] = 1'b1;
            end
            #1;
            check($sformatf("rnd%0d busy", n), {16'b0, busy}, {16'b0, m_busy});
            check($sformatf("rnd%0d reserve_err", n), {31'b0, rerr}, {31'b0, m_err});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
